cb_retire_unit: RTL and testbench

//  Retire stage directly downstream of the completion buffer (CB). Consumes the CB head-commit stream
//  (scalar_commit_ena, vd_final, wdata_final, exception/mispredict flags) and drives the register-file

---
 rtl/rv32i_types_pkg.sv | 34 +++
 rtl/retire_flush_timer.sv | 32 +++
 rtl/cb_retire_unit.sv | 164 ++++++++++++++++
 tb/tb_cb_retire_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared types and constants for the retire stage behind the completion buffer.
//   commit_state_t : retire sequencer states (RUN, VWAIT, FLUSH)
//   retire_cause_t : trap cause code reported alongside epc
//   TRAP_VECTOR    : fetch address used when a committing instruction faults
//   retire_rec_t   : the head-of-CB fields the retire stage acts on
package rv32i_types_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        VWAIT = 2'd1,
        FLUSH = 2'd2
    } commit_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_ILLEGAL  = 2'd1,
        CAUSE_MAL_PRIV = 2'd2
    } retire_cause_t;

    localparam logic [31:0] TRAP_VECTOR = 32'h0000_0080;

    typedef struct packed {
        logic [4:0]  vd;
        logic [31:0] wdata;
        logic [31:0] pc;
    } retire_rec_t;

    // Misaligned/privilege faults get their own cause code; everything else
    // is reported as illegal/other.
    function automatic retire_cause_t fault_cause(input logic mal_priv);
        return mal_priv ? CAUSE_MAL_PRIV : CAUSE_ILLEGAL;
    endfunction

endpackage

// File: rtl/retire_flush_timer.sv
// Down-counter that times the flush window of the retire stage.
//   CLK, nRST : clock and asynchronous active-low reset
//   load      : start a new window of FLUSH_CYCLES cycles
//   done      : high during the last cycle of the window
module retire_flush_timer #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic CLK,
    input  logic nRST,
    input  logic load,
    output logic done
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    logic [CW-1:0] count_q;

    // The count sits at FLUSH_CYCLES in the first window cycle and reaches 1
    // in the last, so done marks the cycle in which the window ends.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CW'(FLUSH_CYCLES);
        end else if (count_q != '0) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign done = (count_q == CW'(1));

endmodule

// File: rtl/cb_retire_unit.sv
// Retire stage downstream of the completion buffer.
//   Inputs : head-commit stream from the CB (scalar/vector commit enables,
//            destination, data, pc, fault and mispredict flags, branch target)
//            and vector-pipe completion.
//   Outputs: register-file write port, retire_stall back to the CB,
//            flush_req/redirect to the front end, epc/cause capture and the
//            retired-instruction counter. All outputs are registered.
module cb_retire_unit
    import rv32i_types_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int INSTRET_W    = 64
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 scalar_commit_ena,
    input  logic [4:0]           vd_final,
    input  logic [31:0]          wdata_final,
    input  logic [31:0]          cb_pc,
    input  logic                 cb_exception,
    input  logic                 cb_mal_priv,
    input  logic                 cb_mispredict,
    input  logic [31:0]          cb_target_pc,
    input  logic                 rv32v_commit_ena,
    input  logic                 rv32v_commit_done,
    output logic                 rf_wen,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 retire_stall,
    output logic                 flush_req,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic [31:0]          epc,
    output logic [1:0]           cause,
    output logic [INSTRET_W-1:0] instret
);

    commit_state_t state_q, state_d;
    retire_rec_t   head;

    logic                 timer_load;
    logic                 flush_done;
    logic                 rf_wen_d;
    logic [4:0]           rf_waddr_d;
    logic [31:0]          rf_wdata_d;
    logic                 retire_stall_d;
    logic                 flush_req_d;
    logic                 redirect_valid_d;
    logic [31:0]          redirect_pc_d;
    logic [31:0]          epc_d;
    logic [1:0]           cause_d;
    logic [INSTRET_W-1:0] instret_d;

    assign head = '{vd: vd_final, wdata: wdata_final, pc: cb_pc};

    retire_flush_timer #(
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) u_flush_timer (
        .CLK  (CLK),
        .nRST (nRST),
        .load (timer_load),
        .done (flush_done)
    );

    // Next-state and next-output logic. Outputs hold their value unless a
    // retire event changes them; rf_wen and redirect_valid are single-cycle
    // pulses. A fault beats a mispredict, and a scalar commit beats a vector
    // commit if the CB ever presents both.
    always_comb begin
        state_d          = state_q;
        timer_load       = 1'b0;
        rf_wen_d         = 1'b0;
        rf_waddr_d       = rf_waddr;
        rf_wdata_d       = rf_wdata;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc;
        epc_d            = epc;
        cause_d          = cause;
        instret_d        = instret;

        case (state_q)
            RUN: begin
                if (scalar_commit_ena) begin
                    if (cb_exception) begin
                        epc_d            = head.pc;
                        cause_d          = fault_cause(cb_mal_priv);
                        redirect_pc_d    = TRAP_VECTOR;
                        redirect_valid_d = 1'b1;
                        state_d          = FLUSH;
                        timer_load       = 1'b1;
                    end else begin
                        rf_wen_d   = (head.vd != 5'd0);
                        rf_waddr_d = head.vd;
                        rf_wdata_d = head.wdata;
                        instret_d  = instret + INSTRET_W'(1);
                        if (cb_mispredict) begin
                            redirect_pc_d    = cb_target_pc;
                            redirect_valid_d = 1'b1;
                            state_d          = FLUSH;
                            timer_load       = 1'b1;
                        end
                    end
                end else if (rv32v_commit_ena) begin
                    if (rv32v_commit_done) begin
                        instret_d = instret + INSTRET_W'(1);
                    end else begin
                        state_d = VWAIT;
                    end
                end
            end
            VWAIT: begin
                if (rv32v_commit_done) begin
                    instret_d = instret + INSTRET_W'(1);
                    state_d   = RUN;
                end
            end
            FLUSH: begin
                if (flush_done) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        flush_req_d    = (state_d == FLUSH);
        retire_stall_d = (state_d != RUN);
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q        <= RUN;
            rf_wen         <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            retire_stall   <= 1'b0;
            flush_req      <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            epc            <= '0;
            cause          <= '0;
            instret        <= '0;
        end else begin
            state_q        <= state_d;
            rf_wen         <= rf_wen_d;
            rf_waddr       <= rf_waddr_d;
            rf_wdata       <= rf_wdata_d;
            retire_stall   <= retire_stall_d;
            flush_req      <= flush_req_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            epc            <= epc_d;
            cause          <= cause_d;
            instret        <= instret_d;
        end
    end

    // The CB must never offer a scalar and a vector commit together.
    a_no_dual_commit : assert property (@(posedge CLK) disable iff (!nRST)
        !(state_q == RUN && scalar_commit_ena && rv32v_commit_ena));

endmodule

// File: tb/tb_cb_retire_unit.sv
// Self-checking bench for cb_retire_unit: directed scenarios with literal
// expectations, then randomized commit traffic checked every cycle against
// a behavioural model. A second instance with a 4-bit counter exercises wrap.
module tb_cb_retire_unit;

    localparam int          FC       = 2;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0080;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        scalar_commit_ena = 1'b0;
    logic [4:0]  vd_final = '0;
    logic [31:0] wdata_final = '0;
    logic [31:0] cb_pc = '0;
    logic        cb_exception = 1'b0;
    logic        cb_mal_priv = 1'b0;
    logic        cb_mispredict = 1'b0;
    logic [31:0] cb_target_pc = '0;
    logic        rv32v_commit_ena = 1'b0;
    logic        rv32v_commit_done = 1'b0;

    logic        rf_wen, retire_stall, flush_req, redirect_valid;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, redirect_pc, epc;
    logic [1:0]  cause;
    logic [63:0] instret;

    logic        rf_wen2, retire_stall2, flush_req2, redirect_valid2;
    logic [4:0]  rf_waddr2;
    logic [31:0] rf_wdata2, redirect_pc2, epc2;
    logic [1:0]  cause2;
    logic [3:0]  instret2;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int          m_flush_left;
    bit          m_vec_busy;
    logic [63:0] m_count;
    logic        m_rf_wen, m_redirect_valid;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata, m_redirect_pc, m_epc;
    logic [1:0]  m_cause;

    always #5 CLK = ~CLK;

    cb_retire_unit #(.FLUSH_CYCLES(FC), .INSTRET_W(64)) dut (
        .CLK(CLK), .nRST(nRST),
        .scalar_commit_ena(scalar_commit_ena), .vd_final(vd_final),
        .wdata_final(wdata_final), .cb_pc(cb_pc), .cb_exception(cb_exception),
        .cb_mal_priv(cb_mal_priv), .cb_mispredict(cb_mispredict),
        .cb_target_pc(cb_target_pc), .rv32v_commit_ena(rv32v_commit_ena),
        .rv32v_commit_done(rv32v_commit_done),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire_stall(retire_stall), .flush_req(flush_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .epc(epc), .cause(cause), .instret(instret)
    );

    cb_retire_unit #(.FLUSH_CYCLES(FC), .INSTRET_W(4)) dut_narrow (
        .CLK(CLK), .nRST(nRST),
        .scalar_commit_ena(scalar_commit_ena), .vd_final(vd_final),
        .wdata_final(wdata_final), .cb_pc(cb_pc), .cb_exception(cb_exception),
        .cb_mal_priv(cb_mal_priv), .cb_mispredict(cb_mispredict),
        .cb_target_pc(cb_target_pc), .rv32v_commit_ena(rv32v_commit_ena),
        .rv32v_commit_done(rv32v_commit_done),
        .rf_wen(rf_wen2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2),
        .retire_stall(retire_stall2), .flush_req(flush_req2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .epc(epc2), .cause(cause2), .instret(instret2)
    );

    // Compare one observed value against its required value and log misses.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle's worth of CB inputs.
    task automatic applyStimulus(input logic sc, input logic [4:0] vd, input logic [31:0] wd,
                                 input logic [31:0] pc, input logic exc, input logic mp,
                                 input logic mis, input logic [31:0] tgt,
                                 input logic ve, input logic vdone);
        scalar_commit_ena = sc;
        vd_final          = vd;
        wdata_final       = wd;
        cb_pc             = pc;
        cb_exception      = exc;
        cb_mal_priv       = mp;
        cb_mispredict     = mis;
        cb_target_pc      = tgt;
        rv32v_commit_ena  = ve;
        rv32v_commit_done = vdone;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Reference behaviour: while a flush window is open every input is
    // ignored; while a vector op is outstanding only completion matters;
    // otherwise a scalar commit retires (or traps) and a vector commit either
    // retires at once or starts waiting.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_flush_left = 0; m_vec_busy = 0; m_count = '0;
            m_rf_wen = 0; m_redirect_valid = 0; m_waddr = '0; m_wdata = '0;
            m_redirect_pc = '0; m_epc = '0; m_cause = '0;
        end else begin
            m_rf_wen = 0;
            m_redirect_valid = 0;
            if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (m_vec_busy) begin
                if (rv32v_commit_done) begin
                    m_vec_busy = 0;
                    m_count++;
                end
            end else if (scalar_commit_ena) begin
                if (cb_exception) begin
                    m_epc = cb_pc;
                    m_cause = cb_mal_priv ? 2'd2 : 2'd1;
                    m_redirect_pc = TRAP_VEC;
                    m_redirect_valid = 1;
                    m_flush_left = FC;
                end else begin
                    m_rf_wen = (vd_final != 0);
                    m_waddr = vd_final;
                    m_wdata = wdata_final;
                    m_count++;
                    if (cb_mispredict) begin
                        m_redirect_pc = cb_target_pc;
                        m_redirect_valid = 1;
                        m_flush_left = FC;
                    end
                end
            end else if (rv32v_commit_ena) begin
                if (rv32v_commit_done) m_count++;
                else m_vec_busy = 1;
            end
        end
    end

    // Cycle-by-cycle comparison, half a period after each active edge.
    always @(negedge CLK) begin
        checkOutput("rf_wen", {63'd0, rf_wen}, {63'd0, m_rf_wen});
        if (m_rf_wen) begin
            checkOutput("rf_waddr", {59'd0, rf_waddr}, {59'd0, m_waddr});
            checkOutput("rf_wdata", {32'd0, rf_wdata}, {32'd0, m_wdata});
        end
        checkOutput("flush_req", {63'd0, flush_req}, {63'd0, (m_flush_left > 0)});
        checkOutput("retire_stall", {63'd0, retire_stall},
                    {63'd0, (m_flush_left > 0) || m_vec_busy});
        checkOutput("redirect_valid", {63'd0, redirect_valid}, {63'd0, m_redirect_valid});
        if (m_redirect_valid)
            checkOutput("redirect_pc", {32'd0, redirect_pc}, {32'd0, m_redirect_pc});
        checkOutput("epc", {32'd0, epc}, {32'd0, m_epc});
        checkOutput("cause", {62'd0, cause}, {62'd0, m_cause});
        checkOutput("instret", instret, m_count);
        checkOutput("instret_narrow", {60'd0, instret2}, {60'd0, m_count[3:0]});
        checkOutput("flush_req_narrow", {63'd0, flush_req2}, {63'd0, (m_flush_left > 0)});
    end

    initial begin
        idle();
        repeat (3) @(negedge CLK);
        checkOutput("reset_instret", instret, 64'd0);
        checkOutput("reset_stall", {63'd0, retire_stall}, 64'd0);
        nRST = 1'b1;

        // Plain scalar write
        applyStimulus(1, 5'd5, 32'hDEADBEEF, 32'h40, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        checkOutput("dir_wen", {63'd0, rf_wen}, 64'd1);
        checkOutput("dir_waddr", {59'd0, rf_waddr}, 64'd5);
        checkOutput("dir_wdata", {32'd0, rf_wdata}, 64'hDEADBEEF);
        checkOutput("dir_instret1", instret, 64'd1);

        // Write to x0 is counted but not written
        applyStimulus(1, 5'd0, 32'h12345678, 32'h44, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        checkOutput("dir_x0_wen", {63'd0, rf_wen}, 64'd0);
        checkOutput("dir_instret2", instret, 64'd2);

        // Fault with mispredict also set: only the trap path is taken
        applyStimulus(1, 5'd9, 32'h55, 32'h100, 1, 1, 1, 32'h2000, 0, 0);
        @(negedge CLK);
        checkOutput("dir_exc_rv", {63'd0, redirect_valid}, 64'd1);
        checkOutput("dir_exc_rpc", {32'd0, redirect_pc}, {32'd0, TRAP_VEC});
        checkOutput("dir_exc_epc", {32'd0, epc}, 64'h100);
        checkOutput("dir_exc_cause", {62'd0, cause}, 64'd2);
        checkOutput("dir_exc_flush1", {63'd0, flush_req}, 64'd1);
        checkOutput("dir_exc_wen", {63'd0, rf_wen}, 64'd0);
        checkOutput("dir_exc_instret", instret, 64'd2);
        // Commit offered inside the flush window must be dropped
        applyStimulus(1, 5'd7, 32'h77, 32'h104, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        checkOutput("dir_exc_flush2", {63'd0, flush_req}, 64'd1);
        checkOutput("dir_exc_rv_pulse", {63'd0, redirect_valid}, 64'd0);
        idle();
        @(negedge CLK);
        checkOutput("dir_exc_flush_end", {63'd0, flush_req}, 64'd0);
        checkOutput("dir_flush_ignored", instret, 64'd2);

        // Mispredict alone: writes, counts and redirects to the target
        applyStimulus(1, 5'd3, 32'h11, 32'h200, 0, 0, 1, 32'h2000, 0, 0);
        @(negedge CLK);
        checkOutput("dir_mp_wen", {63'd0, rf_wen}, 64'd1);
        checkOutput("dir_mp_rpc", {32'd0, redirect_pc}, 64'h2000);
        checkOutput("dir_mp_instret", instret, 64'd3);
        checkOutput("dir_mp_epc_hold", {32'd0, epc}, 64'h100);
        idle();
        repeat (2) @(negedge CLK);

        // Vector commit finishing three cycles later
        applyStimulus(0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0);
        @(negedge CLK);
        idle();
        checkOutput("dir_v_stall1", {63'd0, retire_stall}, 64'd1);
        @(negedge CLK);
        checkOutput("dir_v_stall2", {63'd0, retire_stall}, 64'd1);
        @(negedge CLK);
        checkOutput("dir_v_stall3", {63'd0, retire_stall}, 64'd1);
        applyStimulus(0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        checkOutput("dir_v_unstall", {63'd0, retire_stall}, 64'd0);
        checkOutput("dir_v_instret", instret, 64'd4);
        // Vector commit completing in the same cycle
        applyStimulus(0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 1);
        @(negedge CLK);
        idle();
        checkOutput("dir_v0_stall", {63'd0, retire_stall}, 64'd0);
        checkOutput("dir_v0_instret", instret, 64'd5);
        @(negedge CLK);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                int f;
                f = $urandom_range(0, 5);
                applyStimulus(1, 5'($urandom_range(0, 31)), $urandom, $urandom,
                              f == 0, 1'($urandom_range(0, 1)), f == 1 || f == 0,
                              $urandom, 0, 1'($urandom_range(0, 9) < 3));
            end else if (sel < 8) begin
                applyStimulus(0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0, 1,
                              1'($urandom_range(0, 9) < 3));
            end else begin
                applyStimulus(0, 5'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0,
                              1'($urandom_range(0, 9) < 3));
            end
            @(negedge CLK);
        end
        idle();
        repeat (4) @(negedge CLK);

        // Asynchronous reset landing inside a flush window
        applyStimulus(1, 5'd1, 32'h1, 32'h300, 1, 0, 0, 0, 0, 0);
        @(negedge CLK);
        idle();
        checkOutput("dir_pre_rst_flush", {63'd0, flush_req}, 64'd1);
        #2 nRST = 1'b0;
        #1;
        checkOutput("dir_rst_flush", {63'd0, flush_req}, 64'd0);
        checkOutput("dir_rst_stall", {63'd0, retire_stall}, 64'd0);
        checkOutput("dir_rst_rv", {63'd0, redirect_valid}, 64'd0);
        checkOutput("dir_rst_epc", {32'd0, epc}, 64'd0);
        checkOutput("dir_rst_cause", {62'd0, cause}, 64'd0);
        checkOutput("dir_rst_instret", instret, 64'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // Counter wrap on the narrow instance: all-ones then one more retire
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, 5'd2, 32'(i), 32'h400, 0, 0, 0, 0, 0, 0);
            @(negedge CLK);
        end
        checkOutput("dir_wrap_allones", {60'd0, instret2}, 64'hF);
        applyStimulus(1, 5'd2, 32'h99, 32'h400, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        idle();
        checkOutput("dir_wrap_zero", {60'd0, instret2}, 64'd0);
        checkOutput("dir_wrap_wide", instret, 64'd16);
        @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
